fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the instruction memory.
- The instruction memory is combinational (address in, instruction out in the same cycle); fetch_unit captures the returned word into a small FIFO.
- The FIFO presents {pc, inst} to decode under a valid/ready handshake; branch/jump redirects flush it.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and
// queues {pc, inst} for decode. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      q_pc_q   [DEPTH];
  logic [31:0]      q_inst_q [DEPTH];

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic [31:0]      head_pc_s;
  logic [31:0]      head_inst_s;
  logic             unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  assign imem_addr   = pc_q;
  assign full_s      = (count_q == CNT_W'(DEPTH));
  assign out_valid   = (count_q != {CNT_W{1'b0}});
  assign pop_s       = out_valid & out_ready;
  assign push_s      = ~redirect_valid & (~full_s | pop_s);
  assign head_pc_s   = q_pc_q[rd_q];
  assign head_inst_s = q_inst_q[rd_q];

  // Head entry is presented only while valid; an empty queue shows all zeros.
  always_comb begin
    if (out_valid) begin
      out_pc       = head_pc_s;
      out_inst     = head_inst_s;
      out_pc_plus4 = head_pc_s + 32'd4;
    end else begin
      out_pc       = 32'h0000_0000;
      out_inst     = 32'h0000_0000;
      out_pc_plus4 = 32'h0000_0000;
    end
  end

  // Next-state for PC, pointers and occupancy; a redirect overrides push and pop.
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      rd_d    = {PTR_W{1'b0}};
      wr_d    = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + PTR_W'(1);
      end else begin
        pc_d = pc_q;
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_ALIGNED;
      rd_q    <= {PTR_W{1'b0}};
      wr_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Queue storage: tail write on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= 32'h0000_0000;
        q_inst_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      q_pc_q[wr_q]   <= pc_q;
      q_inst_q[wr_q] <= imem_inst;
    end else begin
      q_pc_q[wr_q]   <= q_pc_q[wr_q];
      q_inst_q[wr_q] <= q_inst_q[wr_q];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;
  logic        stall_s;

  assign stall_s     = full_s & ~pop_s & ~redirect_valid;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= push_s  ? fetch_count_q + 32'd1 : fetch_count_q;
      stall_count_q <= stall_s ? stall_count_q + 32'd1 : stall_count_q;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;

  logic [31:0] imem_addr, imem_inst, out_inst, out_pc, out_pc_plus4;
  logic        out_valid;
  logic [31:0] w_imem_addr, w_imem_inst, w_out_inst, w_out_pc, w_out_pc_plus4;
  logic        w_out_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] mq[$];
  int unsigned m_fc;
  int unsigned m_sc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_inst   = mem_word(imem_addr);
  assign w_imem_inst = mem_word(w_imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_inst(w_out_inst),
    .out_pc(w_out_pc), .out_pc_plus4(w_out_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  // Drive one cycle of inputs, advance the model, and return at the next falling edge.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic m_pop, m_push;
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    if (r) begin
      m_pc = 32'h0000_0000; mq.delete(); m_fc = 0; m_sc = 0;
    end else begin
      m_pop = (mq.size() != 0) && rdy;
      if (!rv && mq.size() == DEPTH && !m_pop) m_sc++;
      if (rv) begin
        mq.delete();
        m_pc = rp & 32'hFFFF_FFFC;
      end else begin
        m_push = (mq.size() < DEPTH) || m_pop;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_fc++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_pc, out_inst, out_pc_plus4} !== 97'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b pc=%h inst=%h p4=%h want all 0", out_valid, out_pc, out_inst, out_pc_plus4);
    end
    n_checks++;
    if (imem_addr !== 32'h0 || w_imem_addr !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL reset_pc: got %h/%h want 00000000/fffffff8", imem_addr, w_imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_inst !== 32'h1000_0000 + 32'(i)
          || out_pc_plus4 !== 32'(4 * i + 4) || imem_addr !== 32'(4 * i + 4)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%0b pc=%h inst=%h p4=%h addr=%h want pc=%h", i,
                 out_valid, out_pc, out_inst, out_pc_plus4, imem_addr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      exp_addr = (k >= 2) ? 32'h8 : 32'(4 * k);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%0b pc=%h addr=%h want v=1 pc=0 addr=%h", k, out_valid, out_pc, imem_addr, exp_addr);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== mem_word(32'(4 * k))) begin
        n_fail++;
        $display("FAIL bp_release[%0d]: got v=%0b pc=%h inst=%h want pc=%h", k, out_valid, out_pc, out_inst, 32'(4 * k));
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (stall_count !== 32'(m_sc) || fetch_count !== 32'(m_fc)) begin
      n_fail++;
      $display("FAIL bp_counters: got f=%0d s=%0d want f=%0d s=%0d", fetch_count, stall_count, m_fc, m_sc);
    end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%0b addr=%h want v=0 addr=00000100", out_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%0b pc=%h inst=%h want pc=00000100", out_valid, out_pc, out_inst);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_next: got v=%0b pc=%h want pc=00000104", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL redir_pop_flush: got v=%0b addr=%h want v=0 addr=00000200", out_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_pop_target: got v=%0b pc=%h want pc=00000200", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (w_out_valid !== 1'b1 || w_out_pc !== exp_pc[i] || w_out_pc_plus4 !== exp_pc[i] + 32'd4
          || w_out_inst !== mem_word(exp_pc[i])) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h p4=%h inst=%h want pc=%h", i, w_out_valid, w_out_pc, w_out_pc_plus4, w_out_inst, exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0400, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%0b addr=%h want v=0 addr=00000000", out_valid, imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_counters: got f=%0d s=%0d want 0/0", fetch_count, stall_count);
    end
`endif
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got v=%0b pc=%h want pc=00000000", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic        r, rv, rdy;
    logic [31:0] rp, exp_pc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rp  = $urandom;
      tick(r, rv, rp, rdy);
      n_checks++;
      if (out_valid !== (mq.size() != 0) || imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: got v=%0b addr=%h want v=%0b addr=%h", i, out_valid, imem_addr, mq.size() != 0, m_pc);
      end else if (mq.size() != 0) begin
        exp_pc = mq[0];
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc) || out_pc_plus4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got pc=%h inst=%h p4=%h want pc=%h inst=%h", i, out_pc, out_inst, out_pc_plus4, exp_pc, mem_word(exp_pc));
        end
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (fetch_count !== 32'(m_fc) || stall_count !== 32'(m_sc)) begin
        n_fail++;
        $display("FAIL rand_counters[%0d]: got f=%0d s=%0d want f=%0d s=%0d", i, fetch_count, stall_count, m_fc, m_sc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
